// File: rtl/cordic_atan_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC atan core among several clients.
// Optional core-latency watchdog enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_atan_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_y,
  output logic [NUM_REQUESTERS-1:0]            resp_valid,
  input  logic [NUM_REQUESTERS-1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0]                resp_angle,
  output logic                                 resp_error,
  output logic                                 core_start,
  output logic [DATA_WIDTH-1:0]                core_x,
  output logic [DATA_WIDTH-1:0]                core_y,
  input  logic                                 core_valid,
  input  logic [DATA_WIDTH-1:0]                core_angle,
  output logic                                 busy,
  output logic [$clog2(NUM_REQUESTERS)-1:0]    grant_id
);

  localparam int unsigned IdW = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]        grant_q, grant_d;
  logic [DATA_WIDTH-1:0] core_x_q, core_x_d;
  logic [DATA_WIDTH-1:0] core_y_q, core_y_d;
  logic [DATA_WIDTH-1:0] resp_angle_q, resp_angle_d;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TimerW-1:0] timer_q, timer_d;
  logic              resp_error_q, resp_error_d;
`endif

  logic [DATA_WIDTH-1:0]     x_arr [NUM_REQUESTERS];
  logic [DATA_WIDTH-1:0]     y_arr [NUM_REQUESTERS];
  logic                      found;
  logic [IdW-1:0]            pick;
  logic [IdW-1:0]            idx;
  logic [NUM_REQUESTERS-1:0] pick_oh;

  always_comb begin
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      x_arr[i] = req_x[i*DATA_WIDTH +: DATA_WIDTH];
      y_arr[i] = req_y[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First requester at or after rr_ptr, wrapping modulo NUM_REQUESTERS.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx     = '0;
    pick_oh = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (32'(rr_ptr_q) + i >= NUM_REQUESTERS) begin
        idx = IdW'(32'(rr_ptr_q) + i - NUM_REQUESTERS);
      end else begin
        idx = IdW'(32'(rr_ptr_q) + i);
      end
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    pick_oh[pick] = found;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    core_x_d     = core_x_q;
    core_y_d     = core_y_q;
    resp_angle_d = resp_angle_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
    timer_d      = timer_q;
    resp_error_d = resp_error_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = pick;
          core_x_d = x_arr[pick];
          core_y_d = y_arr[pick];
          state_d  = StIssue;
        end
      end
      StIssue: begin
`ifdef CORDIC_ARB_TIMEOUT_EN
        timer_d = '0;
`endif
        state_d = StWait;
      end
      StWait: begin
        if (core_valid) begin
          resp_angle_d = core_angle;
          state_d      = StResp;
`ifdef CORDIC_ARB_TIMEOUT_EN
          resp_error_d = 1'b0;
        end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
          // Counter would reach TIMEOUT_CYCLES this cycle: give up on the core.
          resp_angle_d = '0;
          resp_error_d = 1'b1;
          state_d      = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      StResp: begin
        if (resp_ready[grant_q]) begin
          rr_ptr_d = (grant_q == IdW'(NUM_REQUESTERS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = StIdle;
`ifdef CORDIC_ARB_TIMEOUT_EN
          resp_error_d = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      core_x_q     <= '0;
      core_y_q     <= '0;
      resp_angle_q <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      timer_q      <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      core_x_q     <= core_x_d;
      core_y_q     <= core_y_d;
      resp_angle_q <= resp_angle_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
      timer_q      <= timer_d;
      resp_error_q <= resp_error_d;
`endif
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == StResp) begin
      resp_valid[grant_q] = 1'b1;
    end
  end

  assign req_ready  = (state_q == StIdle) ? pick_oh : '0;
  assign core_start = (state_q == StIssue);
  assign busy       = (state_q != StIdle);
  assign grant_id   = grant_q;
  assign core_x     = core_x_q;
  assign core_y     = core_y_q;
  assign resp_angle = resp_angle_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_atan_arbiter.sv
// Scoreboard bench for cordic_atan_arbiter with a behavioural fixed-latency core model.
// Build with CORDIC_ARB_TIMEOUT_EN defined to also exercise the watchdog.
module tb_cordic_atan_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*DW-1:0] req_x, req_y;
  logic [DW-1:0]   resp_angle, core_x, core_y, core_angle;
  logic            resp_error, core_start, core_valid, busy;
  logic [1:0]      grant_id;

  cordic_atan_arbiter #(
    .DATA_WIDTH    (DW),
    .NUM_REQUESTERS(N),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_angle(resp_angle),
    .resp_error(resp_error),
    .core_start(core_start),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_valid(core_valid),
    .core_angle(core_angle),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x, input logic [DW-1:0] y);
    if (x == y) return 32'h0000C90F;
    return x ^ {y[15:0], y[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Core model: fixed latency, optional silence, optional stray pulse.
  int            core_lat  = 4;
  bit            core_mute = 1'b0;
  bit            stray     = 1'b0;
  int            cnt       = 0;
  logic [DW-1:0] cx, cy;

  initial begin
    core_valid = 1'b0;
    core_angle = '0;
    forever begin
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      if (stray) begin
        core_valid = 1'b1;
        core_angle = 32'hDEADBEEF;
        stray      = 1'b0;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_valid = 1'b1;
          core_angle = core_fn(cx, cy);
        end
      end
      if (core_start && !core_mute) begin
        cnt = core_lat;
        cx  = core_x;
        cy  = core_y;
      end
    end
  end

  // Scoreboard and reference arbitration model.
  typedef struct {
    int            id;
    logic [DW-1:0] angle;
    logic          err;
  } exp_t;

  exp_t q[$];
  int   grant_log[$];
  int   grant_cycles[$];
  bit   mbusy    = 1'b0;
  bit   gnt_last = 1'b0;
  int   mptr     = 0;
  int   grant_cyc, start_cyc, resp_cyc;
  bit   resp_seen;

  always @(negedge clk) begin
    logic [N-1:0] exp_oh;
    int           pick;
    exp_t         e;
    if (reset) begin
      q.delete();
      mbusy    = 1'b0;
      gnt_last = 1'b0;
      mptr     = 0;
    end else begin
      exp_oh = '0;
      pick   = -1;
      if (!mbusy) begin
        for (int i = 0; i < N; i++) begin
          if (pick < 0 && req_valid[(mptr + i) % N]) pick = (mptr + i) % N;
        end
      end
      if (pick >= 0) exp_oh[pick] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_oh));
      check("busy", 64'(busy), 64'(mbusy));
      check("core_start", 64'(core_start), 64'(gnt_last));
      gnt_last = (pick >= 0);
      if (core_start) start_cyc = cyc;
      if (pick >= 0) begin
        e.id    = pick;
        e.angle = core_mute ? '0 : core_fn(req_x[pick*DW +: DW], req_y[pick*DW +: DW]);
        e.err   = core_mute;
        q.push_back(e);
        mbusy     = 1'b1;
        grant_cyc = cyc;
        resp_seen = 1'b0;
        grant_log.push_back(pick);
        grant_cycles.push_back(cyc);
      end else if (mbusy && q.size() > 0) begin
        check("grant_id", 64'(grant_id), 64'(q[0].id));
      end
      if (resp_valid != '0) begin
        if (q.size() == 0) begin
          check("resp_stray", 64'(resp_valid), 64'(0));
        end else begin
          e      = q[0];
          exp_oh = '0;
          exp_oh[e.id] = 1'b1;
          check("resp_valid", 64'(resp_valid), 64'(exp_oh));
          check("resp_angle", 64'(resp_angle), 64'(e.angle));
          check("resp_error", 64'(resp_error), 64'(e.err));
          if (!resp_seen) resp_cyc = cyc;
          resp_seen = 1'b1;
          if (resp_ready[e.id]) begin
            void'(q.pop_front());
            mbusy = 1'b0;
            mptr  = (e.id + 1) % N;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_xy(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y);
    req_x[i*DW +: DW] = x;
    req_y[i*DW +: DW] = y;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || q.size() != 0) && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) check("wait_idle", 64'(busy), 64'(0));
  endtask

  task automatic wait_resp(input int id, input int budget);
    int k = 0;
    while (!resp_valid[id] && k < budget) begin
      tick(1);
      k++;
    end
    if (k >= budget) check("wait_resp", 64'(resp_valid), 64'(1 << id));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [DW-1:0] held_angle;
    int k;
    reset      = 1'b1;
    req_valid  = '0;
    resp_ready = '0;
    req_x      = '0;
    req_y      = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("rst_grant_id", 64'(grant_id), 64'(0));
    check("rst_core_x", 64'(core_x), 64'(0));
    check("rst_core_y", 64'(core_y), 64'(0));
    check("rst_angle", 64'(resp_angle), 64'(0));
    check("rst_error", 64'(resp_error), 64'(0));
    check("rst_resp_valid", 64'(resp_valid), 64'(0));

    // Stray core result in IDLE must not disturb anything.
    tick(1);
    stray = 1'b1;
    tick(3);
    check("stray_angle", 64'(resp_angle), 64'(0));
    check("stray_busy", 64'(busy), 64'(0));
    check("stray_resp", 64'(resp_valid), 64'(0));

    // Single job from client 2, latency 17.
    core_lat   = 17;
    resp_ready = 4'b0100;
    set_xy(2, 32'h0001_0000, 32'h0001_0000);
    req_valid  = 4'b0100;
    tick(1);
    req_valid  = '0;
    wait_idle(100);
    check("single_start_lat", 64'(start_cyc - grant_cyc), 64'(1));
    check("single_resp_lat", 64'(resp_cyc - grant_cyc), 64'(19));
    check("single_angle", 64'(resp_angle), 64'(32'h0000C90F));

    // Fairness from a fresh pointer under continuous requests.
    do_reset();
    core_lat = 2;
    for (int i = 0; i < N; i++) set_xy(i, $urandom, $urandom);
    grant_log.delete();
    grant_cycles.delete();
    resp_ready = '1;
    req_valid  = '1;
    k = 0;
    while (grant_log.size() < 8 && k < 300) begin
      tick(1);
      k++;
    end
    req_valid = '0;
    if (k >= 300) check("fair_wait", 64'(grant_log.size()), 64'(8));
    wait_idle(100);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check("fair_order", 64'(grant_log[i]), 64'(i % N));
    end
    if (grant_cycles.size() >= 2) begin
      check("fair_period", 64'(grant_cycles[1] - grant_cycles[0]), 64'(5));
    end

    // Backpressure on client 1 while it and client 0 keep requesting.
    core_lat   = 3;
    set_xy(1, 32'h0000_4000, 32'h0002_0000);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    tick(1);
    req_valid  = 4'b0011;
    wait_resp(1, 50);
    held_angle = resp_angle;
    tick(10);
    check("bp_resp_valid", 64'(resp_valid), 64'(4'b0010));
    check("bp_angle", 64'(resp_angle), 64'(held_angle));
    req_valid  = '0;
    resp_ready = '1;
    wait_idle(50);

    // Reset while in WAIT; the late core pulse must be dropped.
    core_lat = 5;
    set_xy(2, 32'h0003_0000, 32'h0000_1000);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(5);
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_resp", 64'(resp_valid), 64'(0));
    core_lat = 3;
    set_xy(1, 32'h0000_2000, 32'h0000_7000);
    set_xy(3, 32'h0000_5000, 32'h0000_6000);
    grant_log.delete();
    req_valid = 4'b1010;
    tick(1);
    req_valid = '0;
    check("mid_rst_next_grant", 64'(grant_id), 64'(1));
    wait_idle(50);

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Silent core: watchdog must answer with an error.
    core_mute = 1'b1;
    set_xy(0, 32'h0000_1111, 32'h0000_2222);
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    wait_resp(0, 200);
    tick(1);
    check("timeout_lat", 64'(resp_cyc - grant_cyc), 64'(66));
    wait_idle(50);
    core_mute = 1'b0;
    check("timeout_err_clr", 64'(resp_error), 64'(0));
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/cordic_atan_arbiter.md
# cordic_atan_arbiter

Shares one iterative CORDIC arctangent core among `NUM_REQUESTERS` clients using round-robin arbitration. Each accepted job is issued to the core, the result is awaited, and it is returned only to the requester that submitted the job. Only one job is in flight at a time. The block sits between the client-side valid/ready ports and the core's x/y/start/valid/angle interface.

## Interface
- `DATA_WIDTH`, 32: width of x, y and angle (Q16.16 fixed point, passed through unchanged).
- `NUM_REQUESTERS`, 4: number of clients, 2..8.
- `TIMEOUT_CYCLES`, 64: watchdog limit on core latency, only used with the timeout feature.
- `clk` in, 1: clock; everything is on the rising edge.
- `reset` in, 1: synchronous, active-high reset.
- `req_valid` in, NUM_REQUESTERS: one bit per client; a job is offered.
- `req_ready` out, NUM_REQUESTERS: one-hot or zero; the job is accepted this cycle.
- `req_x` in, NUM_REQUESTERS*DATA_WIDTH: flattened x; client i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_y` in, NUM_REQUESTERS*DATA_WIDTH: flattened y, packed the same way as `req_x`.
- `resp_valid` out, NUM_REQUESTERS: one-hot or zero; result presented to the owning client.
- `resp_ready` in, NUM_REQUESTERS: the client accepts the result.
- `resp_angle` out, DATA_WIDTH: result angle, shared by all clients.
- `resp_error` out, 1: result invalid due to timeout; tied to 0 without the timeout feature.
- `core_start` out, 1: one-cycle pulse that launches the core.
- `core_x` out, DATA_WIDTH: operand to the core, held stable from ISSUE until the job ends.
- `core_y` out, DATA_WIDTH: operand to the core, held stable from ISSUE until the job ends.
- `core_valid` in, 1: the core result is valid (one-cycle pulse).
- `core_angle` in, DATA_WIDTH: core result.
- `busy` out, 1: high in every state except IDLE.
- `grant_id` out, clog2(NUM_REQUESTERS): index of the current owner; valid whenever `busy` is high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Search for the first set `req_valid` bit, starting at `rr_ptr` and wrapping modulo NUM_REQUESTERS.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - Register x/y of client g into `core_x`/`core_y`, set `grant_id` = g, go to ISSUE.
  - With no `req_valid` bit set, stay in IDLE.
- **ISSUE**
  - `core_start` = 1 for exactly this cycle, then go to WAIT.
  - A `core_valid` seen in ISSUE is ignored.
- **WAIT**
  - On `core_valid`, register `core_angle` into `resp_angle` and go to RESP.
- **RESP**
  - `resp_valid[grant_id]` = 1 and `resp_angle` stays stable until `resp_ready[grant_id]`.
  - On that handshake, `rr_ptr` = (grant_id+1) mod NUM_REQUESTERS and the FSM goes to IDLE.
  - `resp_ready` bits of other clients are ignored.
- `req_ready` is 0 in every state except IDLE.
- `core_valid` in IDLE or RESP is ignored, for example a stale result after reset.
- `req_valid` may drop before it is granted; no job is recorded for that client.
- A client may hold `req_valid` high while its own response is pending. It is considered again only once the FSM returns to IDLE.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr` = 0, `grant_id` = 0.
  - `req_ready` = 0, `resp_valid` = 0, `resp_angle` = 0, `resp_error` = 0.
  - `core_start` = 0, `core_x` = 0, `core_y` = 0, `busy` = 0.
- Job timeline, with grant in cycle t:
  - `core_start` is high in cycle t+1.
  - A core latency of L cycles after start gives `core_valid` in cycle t+1+L.
  - `resp_valid` rises in cycle t+2+L.
- Minimum job period with `resp_ready` held high: L+3 cycles.
- Reset asserted in any state: all registers return to their reset values in the next cycle. The in-flight job is dropped with no response, and `rr_ptr` = 0.
- Fairness: under continuous requests from all clients, grants rotate 0,1,…,N-1,0. Each client waits at most N-1 jobs.

## Configuration
- Macro: `CORDIC_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A counter clears on ISSUE and increments every cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without `core_valid`, go to RESP with `resp_angle` = 0 and `resp_error` = 1.
  - `resp_error` clears on the response handshake.
- Without the macro:
  - There is no counter and WAIT lasts indefinitely.
  - `resp_error` is the constant 0.

## Test plan
- Single job: client 2 offers x=0x00010000, y=0x00010000; a core model uses L=17 and returns 0x0000C90F. Required: `req_ready[2]` in cycle 0, `core_start` in cycle 1, `resp_valid[2]` with angle 0x0000C90F in cycle 19.
- Fairness: all 4 clients hold `req_valid` high for 8 jobs. Required grant order: 0,1,2,3,0,1,2,3.
- Response backpressure: client 1's `resp_ready` is held low for 10 cycles. Required: `resp_valid[1]` and `resp_angle` stay stable, `req_ready` stays 0, and no `core_start` occurs.
- Reset mid-job: assert `reset` in WAIT, then the core model pulses `core_valid` 3 cycles later. Required: no `resp_valid`, `busy` = 0, and the next grant goes to the lowest active client.
- Timeout (macro defined, TIMEOUT_CYCLES=64): the core never responds. Required: `resp_valid[g]` appears 64 cycles after entering WAIT, with `resp_error` = 1 and angle 0.
- Stray `core_valid` in IDLE with no requests. Required: no output change.
